// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: merges the sprite driver's two pixel write streams into the
// framebuffer's single write port. Each stream has its own FIFO. Off-screen
// writes are clipped. Writes are issued round-robin over a valid/ready handshake.
//
// Ports:
//   clock, fb_resetting        rising-edge clock; async active-high reset
//   wr1_addr/data/en           port-1 pixel write (19-bit address, 4-bit index)
//   wr2_addr/data/en           port-2 pixel write
//   mem_addr/data/we           registered framebuffer write; held until accepted
//   mem_ready                  memory accepts when mem_we && mem_ready
//   overflow1/overflow2        sticky: an eligible write was dropped on a full FIFO
//   busy                       either FIFO non-empty or a write pending
//
// Build option: define FBW_TRANSPARENT_EN to discard writes whose data equals
// TRANSPARENT_INDEX at the input.
module fb_write_arbiter #(
    parameter int unsigned FIFO_DEPTH        = 8,
    parameter int unsigned FB_PIXELS         = 480000,
    parameter logic [3:0]  TRANSPARENT_INDEX = 4'h0
) (
    input  logic        clock,
    input  logic        fb_resetting,
    input  logic [18:0] wr1_addr,
    input  logic [3:0]  wr1_data,
    input  logic        wr1_en,
    input  logic [18:0] wr2_addr,
    input  logic [3:0]  wr2_data,
    input  logic        wr2_en,
    output logic [18:0] mem_addr,
    output logic [3:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        overflow1,
    output logic        overflow2,
    output logic        busy
);

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned ENT_W  = ADDR_W + DATA_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LIM_W  = ADDR_W + 1;
    // One extra bit so a limit of exactly 2^19 still compares correctly.
    localparam logic [LIM_W-1:0] PIX_LIMIT = LIM_W'(FB_PIXELS);

    // Per-port views of the inputs so both FIFOs come from one generate body.
    logic [ADDR_W-1:0] w_in_addr [2];
    logic [DATA_W-1:0] w_in_data [2];
    logic              w_in_en   [2];
    logic [ENT_W-1:0]  w_head    [2];
    logic [1:0]        w_elig;
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_nonempty;
    logic [1:0]        w_ovf;
    logic              w_free;
    logic              w_load;
    logic              w_sel;
    logic              r_last_grant;

    assign w_in_addr[0] = wr1_addr;
    assign w_in_addr[1] = wr2_addr;
    assign w_in_data[0] = wr1_data;
    assign w_in_data[1] = wr2_data;
    assign w_in_en[0]   = wr1_en;
    assign w_in_en[1]   = wr2_en;

`ifndef FBW_TRANSPARENT_EN
    logic w_unused_cfg;
    assign w_unused_cfg = ^TRANSPARENT_INDEX;
`endif

    // Output register is free when idle or when its current write is accepted.
    // Round-robin: with both FIFOs non-empty, the port not granted last wins.
    always_comb begin
        w_free = 1'b0;
        w_load = 1'b0;
        w_sel  = 1'b0;
        w_pop  = 2'b00;
        w_free = !mem_we || mem_ready;
        w_load = w_free && (|w_nonempty);
        if (w_nonempty == 2'b11) begin
            w_sel = !r_last_grant;
        end else begin
            w_sel = w_nonempty[1];
        end
        w_pop[0] = w_load && !w_sel;
        w_pop[1] = w_load && w_sel;
    end

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_count;
        logic             r_ovf;
        logic             w_full;
        logic             w_in_range;

        assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
        assign w_in_range = ({1'b0, w_in_addr[p]} < PIX_LIMIT);
`ifdef FBW_TRANSPARENT_EN
        assign w_elig[p]  = w_in_en[p] && w_in_range && (w_in_data[p] != TRANSPARENT_INDEX);
`else
        assign w_elig[p]  = w_in_en[p] && w_in_range;
`endif
        // A full FIFO still takes a push when it is popped on the same edge.
        assign w_push[p]     = w_elig[p] && (!w_full || w_pop[p]);
        assign w_nonempty[p] = (r_count != '0);
        assign w_head[p]     = r_mem[r_rptr];
        assign w_ovf[p]      = r_ovf;

        // Entry storage needs no reset: only slots behind the count are read.
        always_ff @(posedge clock) begin
            if (w_push[p]) begin
                r_mem[r_wptr] <= {w_in_addr[p], w_in_data[p]};
            end
        end

        // Pointers wrap naturally since the depth is a power of two.
        always_ff @(posedge clock or posedge fb_resetting) begin
            if (fb_resetting) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_push[p]) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop[p]) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (w_push[p] && !w_pop[p]) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push[p] && w_pop[p]) begin
                    r_count <= r_count - CNT_W'(1);
                end
                if (w_elig[p] && !w_push[p]) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Memory-side output register; last_grant resets to port 2 so port 1 goes first.
    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_free) begin
            if (w_load) begin
                {mem_addr, mem_data} <= w_head[w_sel];
                mem_we               <= 1'b1;
                r_last_grant         <= w_sel;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    assign overflow1 = w_ovf[0];
    assign overflow2 = w_ovf[1];
    assign busy      = (|w_nonempty) | mem_we;

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

    localparam int DEPTH  = 8;
    localparam int FB_PIX = 480000;
`ifdef FBW_TRANSPARENT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        fb_resetting = 1'b0;
    logic [18:0] wr1_addr = '0;
    logic [3:0]  wr1_data = '0;
    logic        wr1_en = 1'b0;
    logic [18:0] wr2_addr = '0;
    logic [3:0]  wr2_data = '0;
    logic        wr2_en = 1'b0;
    logic [18:0] mem_addr;
    logic [3:0]  mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic        overflow1;
    logic        overflow2;
    logic        busy;

    fb_write_arbiter #(
        .FIFO_DEPTH       (DEPTH),
        .FB_PIXELS        (FB_PIX),
        .TRANSPARENT_INDEX(4'h0)
    ) dut (
        .clock       (clock),
        .fb_resetting(fb_resetting),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .wr1_en      (wr1_en),
        .wr2_addr    (wr2_addr),
        .wr2_data    (wr2_data),
        .wr2_en      (wr2_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .overflow1   (overflow1),
        .overflow2   (overflow2),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: two queues, one output slot, round-robin pointer.
    logic [22:0] q1[$];
    logic [22:0] q2[$];
    logic        m_we, m_ovf1, m_ovf2;
    logic [18:0] m_addr;
    logic [3:0]  m_data;
    int          m_last;
    int          pick;

    function automatic bit elig(input bit en, input logic [18:0] a, input logic [3:0] d);
        return en && (int'(a) < FB_PIX) && !(TEN && d == 4'h0);
    endfunction

    always @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            q1.delete();
            q2.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0;
            m_ovf1 = 1'b0; m_ovf2 = 1'b0;
            m_last = 2;
        end else begin
            pick = 0;
            if (!m_we || mem_ready) begin
                if (q1.size() > 0 && q2.size() > 0) pick = (m_last == 2) ? 1 : 2;
                else if (q1.size() > 0) pick = 1;
                else if (q2.size() > 0) pick = 2;
                if (pick == 1) begin
                    {m_addr, m_data} = q1.pop_front(); m_we = 1'b1; m_last = 1;
                end else if (pick == 2) begin
                    {m_addr, m_data} = q2.pop_front(); m_we = 1'b1; m_last = 2;
                end else begin
                    m_we = 1'b0;
                end
            end
            if (elig(wr1_en, wr1_addr, wr1_data)) begin
                if (q1.size() < DEPTH) q1.push_back({wr1_addr, wr1_data});
                else m_ovf1 = 1'b1;
            end
            if (elig(wr2_en, wr2_addr, wr2_data)) begin
                if (q2.size() < DEPTH) q2.push_back({wr2_addr, wr2_data});
                else m_ovf2 = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_data", 32'(mem_data), 32'(m_data));
        chk("overflow1", 32'(overflow1), 32'(m_ovf1));
        chk("overflow2", 32'(overflow2), 32'(m_ovf2));
        chk("busy", 32'(busy), 32'((q1.size() != 0) || (q2.size() != 0) || m_we));
    end

    // Log of writes the DUT actually handed to memory.
    logic [22:0] wlog[$];
    logic [22:0] exp_q[$];
    always @(posedge clock) begin
        if (!fb_resetting && mem_we && mem_ready) wlog.push_back({mem_addr, mem_data});
    end

    task automatic drive(input bit e1, input int a1, input int d1,
                         input bit e2, input int a2, input int d2, input bit rdy);
        @(negedge clock);
        wr1_en = e1; wr1_addr = 19'(a1); wr1_data = 4'(d1);
        wr2_en = e2; wr2_addr = 19'(a2); wr2_data = 4'(d2);
        mem_ready = rdy;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 fb_resetting = 1'b1;
        wr1_en = 1'b0; wr2_en = 1'b0; mem_ready = 1'b1;
        @(negedge clock);
        fb_resetting = 1'b0;
        wlog.delete();
        exp_q.delete();
    endtask

    task automatic expect_w(input int a, input int d);
        exp_q.push_back({19'(a), 4'(d)});
    endtask

    task automatic chk_log(input string nm);
        chk({nm, " count"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            chk({nm, " entry"}, 32'(wlog[i]), 32'(exp_q[i]));
        wlog.delete();
        exp_q.delete();
    endtask

    initial begin
        #1 fb_resetting = 1'b1;
        idle(3, 1);
        chk("reset mem_we", 32'(mem_we), 0);
        chk("reset mem_addr", 32'(mem_addr), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset overflow1", 32'(overflow1), 0);
        @(negedge clock);
        fb_resetting = 1'b0;
        wlog.delete();

        // Single write: pushed at N, issued during N+1..N+2.
        drive(1, 1000, 5, 0, 0, 0, 1);
        idle(1, 1);
        chk("single N mem_we", 32'(mem_we), 0);
        chk("single N busy", 32'(busy), 1);
        idle(1, 1);
        chk("single N+1 mem_we", 32'(mem_we), 1);
        chk("single N+1 addr", 32'(mem_addr), 1000);
        chk("single N+1 data", 32'(mem_data), 5);
        idle(1, 1);
        chk("single N+2 mem_we", 32'(mem_we), 0);
        chk("single N+2 busy", 32'(busy), 0);
        expect_w(1000, 5);
        chk_log("single");

        // Round-robin from reset: port 1 first, then alternate.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, i, 1, 1, 100 + i, 2, 1);
        idle(12, 1);
        for (int i = 0; i < 4; i++) begin expect_w(i, 1); expect_w(100 + i, 2); end
        chk_log("round-robin");

        // Clipping at the last visible pixel.
        drive(1, 479999, 2, 0, 0, 0, 1);
        drive(1, 480000, 2, 0, 0, 0, 1);
        idle(5, 1);
        expect_w(479999, 2);
        chk_log("clip");
        chk("clip overflow1", 32'(overflow1), 0);

        // Backpressure: 1 held, 8 buffered, 1 dropped.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1, 200 + i, 3, 0, 0, 0, 0);
        idle(1, 0);
        chk("bp overflow1", 32'(overflow1), 1);
        chk("bp held addr", 32'(mem_addr), 200);
        chk("bp mem_we", 32'(mem_we), 1);
        chk("bp model depth", 32'(q1.size()), 8);
        idle(15, 1);
        for (int i = 0; i < 9; i++) expect_w(200 + i, 3);
        chk_log("backpressure");

        // Transparency sequence 0,3,0,7.
        do_reset();
        drive(1, 300, 0, 0, 0, 0, 1);
        drive(1, 301, 3, 0, 0, 0, 1);
        drive(1, 302, 0, 0, 0, 0, 1);
        drive(1, 303, 7, 0, 0, 0, 1);
        idle(6, 1);
        if (!TEN) expect_w(300, 0);
        expect_w(301, 3);
        if (!TEN) expect_w(302, 0);
        expect_w(303, 7);
        chk_log("transparency");

        // Reset mid-burst with a stalled output and part-filled FIFOs.
        for (int i = 0; i < 6; i++) drive(1, 400 + i, 4, 1, 500 + i, 6, 0);
        idle(1, 0);
        chk("midburst pre mem_we", 32'(mem_we), 1);
        #2 fb_resetting = 1'b1;
        #1;
        chk("midburst mem_we", 32'(mem_we), 0);
        chk("midburst mem_addr", 32'(mem_addr), 0);
        chk("midburst busy", 32'(busy), 0);
        idle(2, 1);
        @(negedge clock);
        fb_resetting = 1'b0;
        wlog.delete();
        exp_q.delete();
        idle(10, 1);
        chk("post reset busy", 32'(busy), 0);
        chk_log("post reset");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int u1, u2;
            u1 = $urandom;
            u2 = $urandom;
            drive(($urandom % 100) < 40, (u1 % 10 == 0) ? FB_PIX + (u1 % 50) : (u1 % FB_PIX),
                  $urandom % 16,
                  ($urandom % 100) < 40, (u2 % 10 == 0) ? FB_PIX + (u2 % 50) : (u2 % FB_PIX),
                  $urandom % 16,
                  ($urandom % 4) != 0);
        end
        idle(25, 1);
        chk("random drain busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
